// File: rtl/ma_stage_mc_pkg.sv
// Shared definitions for the multi-cycle memory-access stage: MIPS opcodes,
// FSM state encoding and parameter defaults/bounds.
package ma_stage_mc_pkg;

    localparam int DMEM_WORDS_DEF  = 1024;
    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 15;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;
    // JALR lives under the SPECIAL opcode and is told apart by its funct field.
    localparam logic [5:0] FN_JALR    = 6'h09;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ma_state_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ma_stage_mc_dmem.sv
// ma_dmem: single-port data RAM, synchronous byte-enabled write, asynchronous read.
module ma_dmem #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge CLK) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ma_stage_mc.sv
// Multi-cycle MIPS memory-access stage with byte/halfword loads and stores.
// Define MA_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module ma_stage_mc
    import ma_stage_mc_pkg::*;
#(
    parameter int DMEM_WORDS  = DMEM_WORDS_DEF,
    parameter int MEM_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_in,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    input  logic [31:0] nextPC,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] Wdata,
    output logic        misalign
);

    localparam int AW  = $clog2(DMEM_WORDS);
    localparam int LAT = (MEM_LATENCY < MEM_LATENCY_MIN) ? MEM_LATENCY_MIN :
                         (MEM_LATENCY > MEM_LATENCY_MAX) ? MEM_LATENCY_MAX : MEM_LATENCY;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    ma_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0] st_data_q, st_data_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;

    logic [5:0]  in_op;
    logic        in_is_mem, in_is_link, in_mis;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata, load_val;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        unused_in;

    assign unused_in  = ^{Ins[25:6], Result[31:AW+2]};
    assign in_op      = Ins[31:26];
    assign in_is_mem  = is_load(in_op) || is_store(in_op);
    assign in_is_link = (in_op == OP_JAL) || ((in_op == OP_SPECIAL) && (Ins[5:0] == FN_JALR));

`ifdef MA_MISALIGN_TRAP_EN
    assign in_mis = ((in_op == OP_LH || in_op == OP_LHU || in_op == OP_SH) && Result[0]) ||
                    ((in_op == OP_LW || in_op == OP_SW) && (Result[1:0] != 2'b00));
`else
    assign in_mis = 1'b0;
`endif

    // Lane extraction for loads and lane replication/enables for stores.
    always_comb begin
        byte_v    = mem_rdata[8*addr_q[1:0] +: 8];
        half_v    = mem_rdata[16*addr_q[1] +: 16];
        load_val  = mem_rdata;
        mem_be    = 4'b1111;
        mem_wdata = st_data_q;
        case (op_q)
            OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_val = {24'd0, byte_v};
            OP_LH:   load_val = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_val = {16'd0, half_v};
            OP_SB: begin
                mem_be    = 4'b0001 << addr_q[1:0];
                mem_wdata = {4{st_data_q[7:0]}};
            end
            OP_SH: begin
                mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{st_data_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        st_data_d = st_data_q;
        wdata_d   = wdata_q;
        valid_d   = 1'b0;
        mis_d     = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    mem_we  = is_store(op_q);
                    wdata_d = is_store(op_q) ? st_data_q : load_val;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                // IDLE and DONE both accept, so DONE supports back-to-back issue.
                state_d = ST_IDLE;
                if (valid_in) begin
                    if (in_mis) begin
                        wdata_d = 32'd0;
                        valid_d = 1'b1;
                        mis_d   = 1'b1;
                    end else if (in_is_mem) begin
                        op_d      = in_op;
                        addr_d    = Result[AW+1:0];
                        st_data_d = Rdata2;
                        cnt_d     = CNT_INIT;
                        state_d   = ST_BUSY;
                    end else begin
                        wdata_d = in_is_link ? nextPC : Result;
                        valid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_q      <= 6'd0;
            addr_q    <= '0;
            st_data_q <= 32'd0;
            wdata_q   <= 32'd0;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            st_data_q <= st_data_d;
            wdata_q   <= wdata_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
        end
    end

    // A reset landing on the completing edge must not let a store through.
    ma_dmem #(.WORDS(DMEM_WORDS)) u_dmem (
        .CLK   (CLK),
        .we    (mem_we && RST),
        .be    (mem_be),
        .addr  (addr_q[AW+1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign stall     = (state_q == ST_BUSY);
    assign valid_out = valid_q;
    assign Wdata     = wdata_q;
    assign misalign  = mis_q;

endmodule
